uart_mmio_responder: RTL and testbench



---
 rtl/uart_mmio_responder_pkg.sv | 27 ++
 rtl/uart_mmio_responder_if.sv | 26 ++
 rtl/uart_receiver.sv | 93 +++++++++
 rtl/uart_transmitter.sv | 82 ++++++++
 rtl/uart_mmio_responder.sv | 145 ++++++++++++++
 tb/tb_uart_mmio_responder.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/uart_mmio_responder_pkg.sv
// Shared constants for the MMIO UART responder: register offsets,
// status bit positions and UART FSM state encodings.
package uart_mmio_responder_pkg;

    localparam logic [4:0] UART_STATUS_OFF = 5'h00;
    localparam logic [4:0] UART_RX_OFF     = 5'h04;
    localparam logic [4:0] UART_TX_OFF     = 5'h08;
    localparam logic [4:0] CYCLE_CNT_OFF   = 5'h10;
    localparam logic [4:0] CNT_RESET_OFF   = 5'h18;

    localparam int TX_READY_BIT   = 0;
    localparam int RX_VALID_BIT   = 1;
    localparam int RX_OVERRUN_BIT = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef struct packed {
        logic rd_status;
        logic rd_rx;
        logic wr_tx;
        logic wr_cnt_rst;
    } access_t;

endpackage

// File: rtl/uart_mmio_responder_if.sv
// Data-port bundle between the Memory stage and the I/O responder.
interface uart_mmio_responder_if;

    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dout;

    modport master (
        output addr,
        output din,
        output we,
        output re,
        input  dout
    );

    modport slave (
        input  addr,
        input  din,
        input  we,
        input  re,
        output dout
    );

endinterface

// File: rtl/uart_receiver.sv
// 8N1 deserializer with a 2-flop synchronizer; valid pulses for one
// cycle at the stop-bit midpoint while data holds the received byte.
module uart_receiver
    import uart_mmio_responder_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data,
    output logic       valid
);

    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(SYMBOL_EDGE_TIME / 2 - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sync1;
    logic          sync2;
    logic          prev;

    assign data = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (prev && !sync2) begin
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    // a start bit that is high again at mid-symbol was noise
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        valid <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 serializer; ready is high only while idle, so a new byte may be
// launched on the first idle cycle after the previous stop bit.
module uart_transmitter
    import uart_mmio_responder_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       serial_out
);

    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] LAST = CW'(SYMBOL_EDGE_TIME - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            serial_out <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    serial_out <= 1'b1;
                    if (start) begin
                        shreg      <= data;
                        cnt        <= '0;
                        state      <= ST_START;
                        serial_out <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        bit_idx    <= '0;
                        state      <= ST_DATA;
                        serial_out <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state      <= ST_STOP;
                            serial_out <= 1'b1;
                        end else begin
                            serial_out <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// I/O-region responder: UART, cycle counter, one-cycle read latency.
// Optional sticky RX overrun flag in status bit2 via UART_RX_OVERRUN_EN.
module uart_mmio_responder
    import uart_mmio_responder_pkg::*;
#(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE      = 115200
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_mmio_responder_if.slave  bus,
    input  logic                  FPGA_SERIAL_RX,
    output logic                  FPGA_SERIAL_TX
);

    localparam int SYMBOL_EDGE_TIME = CPU_CLOCK_FREQ / BAUD_RATE;

    logic        io;
    logic        store;
    logic [4:0]  word_off;
    logic        hit_status;
    logic        hit_rx;
    logic        hit_tx;
    logic        hit_cnt;
    logic        hit_cnt_rst;
    access_t     acc;
    logic        tx_ready;
    logic        tx_start;
    logic        rx_done;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overrun;
    logic [31:0] cycle_cnt;
    logic [31:0] status_word;
    logic [31:0] rdata;
    logic        unused_bits;

    assign io       = bus.addr[31];
    assign store    = |bus.we;
    assign word_off = {bus.addr[4:2], 2'b00};

    assign hit_status  = io && (word_off == UART_STATUS_OFF);
    assign hit_rx      = io && (word_off == UART_RX_OFF);
    assign hit_tx      = io && (word_off == UART_TX_OFF);
    assign hit_cnt     = io && (word_off == CYCLE_CNT_OFF);
    assign hit_cnt_rst = io && (word_off == CNT_RESET_OFF);

    always_comb begin
        acc            = '0;
        acc.rd_status  = bus.re && hit_status;
        acc.rd_rx      = bus.re && hit_rx;
        acc.wr_tx      = store && bus.we[0] && hit_tx;
        acc.wr_cnt_rst = store && hit_cnt_rst;
    end

    // stores to a busy transmitter are dropped, not queued
    assign tx_start = acc.wr_tx && tx_ready;

    uart_transmitter #(
        .SYMBOL_EDGE_TIME (SYMBOL_EDGE_TIME)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .data       (bus.din[7:0]),
        .start      (tx_start),
        .ready      (tx_ready),
        .serial_out (FPGA_SERIAL_TX)
    );

    uart_receiver #(
        .SYMBOL_EDGE_TIME (SYMBOL_EDGE_TIME)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .serial_in (FPGA_SERIAL_RX),
        .data      (rx_byte),
        .valid     (rx_done)
    );

    // a landing byte takes priority over a concurrent rx_data read
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (rx_done) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_byte;
        end else if (acc.rd_rx) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef UART_RX_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun <= 1'b0;
        end else if (rx_done && rx_valid) begin
            rx_overrun <= 1'b1;
        end else if (acc.rd_status) begin
            rx_overrun <= 1'b0;
        end
    end
    assign unused_bits = ^{bus.addr[30:5], bus.addr[1:0], bus.din[31:8]};
`else
    assign rx_overrun  = 1'b0;
    assign unused_bits = ^{bus.addr[30:5], bus.addr[1:0], bus.din[31:8],
                           acc.rd_status};
`endif

    always_ff @(posedge clk) begin
        if (rst || acc.wr_cnt_rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_comb begin
        status_word                 = '0;
        status_word[TX_READY_BIT]   = tx_ready;
        status_word[RX_VALID_BIT]   = rx_valid;
        status_word[RX_OVERRUN_BIT] = rx_overrun;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_status: rdata = status_word;
            hit_rx:     rdata = {24'b0, rx_data};
            hit_cnt:    rdata = cycle_cnt;
            default:    rdata = '0;
        endcase
    end

    // sampled on the re edge, so a same-cycle store is not yet visible
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout <= '0;
        end else if (bus.re) begin
            bus.dout <= rdata;
        end
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Scoreboard bench for uart_mmio_responder at 10 clocks per UART bit.
module tb_uart_mmio_responder;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_mmio_responder_if bus ();

    uart_mmio_responder #(
        .CPU_CLOCK_FREQ (1000),
        .BAUD_RATE      (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .FPGA_SERIAL_RX (rx),
        .FPGA_SERIAL_TX (tx)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (bus.re === 1'b1) begin
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk(e.tag, bus.dout, e.val);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] w);
        bus.addr = a;
        bus.din  = d;
        bus.we   = w;
        @(posedge clk);
        @(negedge clk);
        bus.we = 4'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] e);
        bus.addr = a;
        bus.re   = 1'b1;
        sb.push_back('{tag: tag, val: e});
        @(posedge clk);
        @(negedge clk);
        bus.re = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx = 1'b0;
        idle(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(10);
        end
        rx = 1'b1;
        idle(10);
    endtask

    task automatic tx_capture(input string tag, input logic [7:0] b);
        int          waited;
        logic [9:0]  fr;
        waited = 0;
        fr     = {1'b1, b, 1'b0};
        while (tx !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_start"}, 32'(tx), 32'd0);
        if (tx === 1'b0) begin
            for (int k = 0; k < 10; k++) begin
                idle(5);
                chk($sformatf("%s_bit%0d", tag, k), 32'(tx), 32'(fr[k]));
                idle(5);
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lows;
        bus.addr = '0;
        bus.din  = '0;
        bus.we   = '0;
        bus.re   = 1'b0;
        rst      = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("rst_dout", bus.dout, 32'h0);
        chk("rst_tx", 32'(tx), 32'd1);

        rd("status_reset", 32'h8000_0000, 32'h1);
        rd("status_alias", 32'h8000_0003, 32'h1);
        rd("unmapped_0c", 32'h8000_000C, 32'h0);
        rd("low_status", 32'h0000_0000, 32'h0);
        rd("low_cnt", 32'h0000_0010, 32'h0);

        wr(32'h0000_0008, 32'h55, 4'b0001);
        rd("low_store", 32'h8000_0000, 32'h1);
        wr(32'h8000_0008, 32'h55, 4'b0010);
        rd("tx_we1_only", 32'h8000_0000, 32'h1);

        fork
            tx_capture("txA5", 8'hA5);
            begin
                wr(32'h8000_0008, 32'hA5, 4'b0001);
                rd("status_busy", 32'h8000_0000, 32'h0);
                idle(20);
                wr(32'h8000_0008, 32'hFF, 4'b0001);
                idle(3);
                rd("status_busy2", 32'h8000_0000, 32'h0);
            end
        join
        rd("status_after_tx", 32'h8000_0000, 32'h1);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        chk("tx_no_second_frame", 32'(lows), 32'd0);

        send_rx(8'h3C);
        rd("rx_status", 32'h8000_0000, 32'h3);
        rd("rx_data", 32'h8000_0004, 32'h3C);
        rd("rx_status_clr", 32'h8000_0000, 32'h1);

        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(120);
        rd("glitch_status", 32'h8000_0000, 32'h1);
        rd("glitch_rxdata", 32'h8000_0004, 32'h3C);

        wr(32'h8000_0018, 32'h0, 4'b1111);
        idle(4);
        rd("cnt_after_clear", 32'h8000_0010, 32'd4);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        rd("cnt_max", 32'h8000_0010, 32'hFFFF_FFFF);
        rd("cnt_wrap", 32'h8000_0010, 32'h0);

        send_rx(8'h11);
        send_rx(8'h22);
`ifdef UART_RX_OVERRUN_EN
        rd("ovr_status", 32'h8000_0000, 32'h7);
`else
        rd("ovr_status", 32'h8000_0000, 32'h3);
`endif
        rd("ovr_rxdata", 32'h8000_0004, 32'h22);
        rd("ovr_status_clr", 32'h8000_0000, 32'h1);

        rx = 1'b0;
        wr(32'h8000_0008, 32'h00, 4'b0001);
        idle(30);
        chk("mid_frame_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_dout", bus.dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        idle(120);
        rd("rst_mid_status", 32'h8000_0000, 32'h1);

        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
